// File: rtl/cipher_pkg.sv
// Shared constants and types for the iterated SPN block cipher.
package cipher_pkg;

  // 4-bit substitution box and its inverse, applied nibble-wise across the block.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Direction encodings; the forward key step reuses ENC.
  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/cipher_round.sv
// One combinational cipher round plus the matching key-schedule step.
// Encrypt: x' = rotl(S(x ^ rk), 1),    rk' = rotl(rk, 3) ^ rc
// Decrypt: x' = Sinv(rotr(x, 1)) ^ rk, rk' = rotr(rk ^ rc, 3)
module cipher_round
  import cipher_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] rk_i,
  input  logic [3:0]       rc_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] rk_o
);

  logic [WIDTH-1:0] mix;
  logic [WIDTH-1:0] sub_fwd;
  logic [WIDTH-1:0] x_rotr;
  logic [WIDTH-1:0] sub_inv;
  logic [WIDTH-1:0] rc_ext;
  logic [WIDTH-1:0] rk_mix;

  assign mix    = x_i ^ rk_i;
  assign x_rotr = {x_i[0], x_i[WIDTH-1:1]};
  assign rc_ext = WIDTH'(rc_i);
  assign rk_mix = rk_i ^ rc_ext;

  for (genvar g = 0; g < WIDTH / 4; g++) begin : g_nib
    assign sub_fwd[4*g +: 4] = SBOX[mix[4*g +: 4]];
    assign sub_inv[4*g +: 4] = SBOX_INV[x_rotr[4*g +: 4]];
  end

  // Select forward or inverse round and key step.
  always_comb begin
    x_o  = '0;
    rk_o = '0;
    if (dir_i == MODE_ENC) begin
      x_o  = {sub_fwd[WIDTH-2:0], sub_fwd[WIDTH-1]};
      rk_o = {rk_i[WIDTH-4:0], rk_i[WIDTH-1:WIDTH-3]} ^ rc_ext;
    end else begin
      x_o  = sub_inv ^ rk_i;
      rk_o = {rk_mix[2:0], rk_mix[WIDTH-1:3]};
    end
  end

endmodule

// File: rtl/iter_block_cipher.sv
// Iterated SPN block cipher: one round per clock, valid/ready in and out.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// EXPAND | decrypt only: stepping the key forward to rk(ROUNDS-1)
// ROUND  | applying one cipher round per cycle
// DONE   | out_valid high, holding the result until accepted
module iter_block_cipher
  import cipher_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);
  // Last EXPAND count; only meaningful when ROUNDS > 1.
  localparam logic [3:0] EXP_LAST = 4'((ROUNDS > 1) ? ROUNDS - 2 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             mode_q, mode_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             dir;
  logic [3:0]       rc;
  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] rk_nxt;

  // EXPAND always steps the key forward; ROUND follows the captured mode.
  // A forward step into rk(i+1) uses constant i+1, a backward step out of rk(i) uses i.
  always_comb begin
    dir = MODE_ENC;
    rc  = cnt_q + 4'd1;
    if (state_q == ST_ROUND) begin
      dir = mode_q;
      if (mode_q == MODE_DEC) rc = cnt_q;
    end
  end

  cipher_round #(
    .WIDTH(WIDTH)
  ) u_round (
    .x_i  (data_q),
    .rk_i (key_q),
    .rc_i (rc),
    .dir_i(dir),
    .x_o  (x_nxt),
    .rk_o (rk_nxt)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter sequencing and handshake outputs.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    key_d     = key_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = data_in;
          key_d  = key;
          mode_d = mode;
          cnt_d  = 4'd0;
          if (mode == MODE_DEC && ROUNDS > 1) state_d = ST_EXPAND;
          else                                state_d = ST_ROUND;
        end
      end
      ST_EXPAND: begin
        busy  = 1'b1;
        key_d = rk_nxt;
        if (cnt_q == EXP_LAST) begin
          cnt_d   = LAST_CNT;
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ROUND: begin
        busy   = 1'b1;
        data_d = x_nxt;
        key_d  = rk_nxt;
        if (mode_q == MODE_ENC) begin
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + 4'd1;
        end else begin
          if (cnt_q == 4'd0) state_d = ST_DONE;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out = data_q;

endmodule
